// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display driver and its capture monitor.
// Holds the active-low segment table, anode one-hot constants, the capture FSM
// state type, the sampled-bus payload struct and small anode helper functions.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned SSEG_W     = 8;
    localparam int unsigned HEX_W      = 4;
    localparam int unsigned STAB_W     = 8;

    // Active-low anode selects, one digit enabled at a time
    localparam logic [AN_W-1:0] AN_D0 = 4'b1110;
    localparam logic [AN_W-1:0] AN_D1 = 4'b1101;
    localparam logic [AN_W-1:0] AN_D2 = 4'b1011;
    localparam logic [AN_W-1:0] AN_D3 = 4'b0111;

    // Active-low {g..a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_e;

    // One sample of the multiplexed display bus
    typedef struct packed {
        logic [AN_W-1:0]   an;
        logic [SSEG_W-1:0] sseg;
    } sample_t;

    // Bus level with every anode and segment off
    localparam sample_t BLANK_SAMPLE = '{an: 4'hF, sseg: 8'hFF};

    // Exactly one anode driven low
    function automatic logic an_valid(input logic [AN_W-1:0] an);
        return $onehot(~an);
    endfunction

    // Digit index for a valid anode pattern
    function automatic logic [1:0] an_index(input logic [AN_W-1:0] an);
        case (an)
            AN_D0:   return 2'd0;
            AN_D1:   return 2'd1;
            AN_D2:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/sseg_mux_capture_if.sv
// Multiplexed seven-segment bus plus the reconstructed digit outputs.
// master: the display driver / bench side; slave: the capture block.
interface sseg_mux_capture_if;
    import sseg_pkg::*;

    logic [AN_W-1:0]       an;
    logic [SSEG_W-1:0]     sseg;
    logic [HEX_W-1:0]      hex0;
    logic [HEX_W-1:0]      hex1;
    logic [HEX_W-1:0]      hex2;
    logic [HEX_W-1:0]      hex3;
    logic [NUM_DIGITS-1:0] dp_out;
    logic [NUM_DIGITS-1:0] digit_valid;
    logic [NUM_DIGITS-1:0] seg_err;
    logic                  frame_tick;

    modport master (
        output an, sseg,
        input  hex0, hex1, hex2, hex3, dp_out, digit_valid, seg_err, frame_tick
    );

    modport slave (
        input  an, sseg,
        output hex0, hex1, hex2, hex3, dp_out, digit_valid, seg_err, frame_tick
    );

endinterface

// File: rtl/sseg_decode.sv
// Inverse segment decode: 7-bit active-low {g..a} pattern -> hit flag and hex value.
// Ports: pattern (in), hit_c (pattern found in table), hex_c (digit value, 0 on miss).
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0]       pattern,
    output logic             hit_c,
    output logic [HEX_W-1:0] hex_c
);

    // Table entries are distinct, so at most one can match
    always_comb begin
        hit_c = 1'b0;
        hex_c = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                hit_c = 1'b1;
                hex_c = HEX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_mux_capture.sv
// Reconstructs four hex digits and decimal points from a time-multiplexed,
// active-low seven-segment bus. A digit is captured once its {an, sseg} value
// has been stable for STABLE_CYCLES samples; frame_tick pulses when all four
// digits have been captured; digit_valid clears after TIMEOUT_CYCLES without capture.
// Ports: clk, rst (sync, active-high), bus (slave modport: an/sseg in, digit state out).
module sseg_mux_capture
    import sseg_pkg::*;
#(
    parameter int unsigned SYNC_EN        = 1,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    sseg_mux_capture_if.slave  bus
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STABLE_N  = STAB_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] TIMEOUT_N = IDLE_W'(TIMEOUT_CYCLES);

    sample_t raw;
    sample_t samp;

    assign raw.an   = bus.an;
    assign raw.sseg = bus.sseg;

    // Optional two-flop synchronizer on the whole bus
    if (SYNC_EN != 0) begin : g_sync
        sample_t meta_q;
        sample_t sync_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_q <= BLANK_SAMPLE;
                sync_q <= BLANK_SAMPLE;
            end else begin
                meta_q <= raw;
                sync_q <= meta_q;
            end
        end
        assign samp = sync_q;
    end else begin : g_nosync
        assign samp = raw;
    end

    state_e                   state_q, state_d;
    sample_t                  snap_q, snap_d;
    logic [STAB_W-1:0]        stab_cnt_q, stab_cnt_d;
    logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
    logic [3:0][HEX_W-1:0]    hex_q, hex_d;
    logic [NUM_DIGITS-1:0]    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]    valid_q, valid_d;
    logic [NUM_DIGITS-1:0]    err_q, err_d;
    logic [NUM_DIGITS-1:0]    seen_q, seen_d;
    logic                     frame_tick_q, frame_tick_d;

    logic                     cur_valid;
    logic                     same;
    logic                     capture_c;
    logic [1:0]               idx;
    logic                     dec_hit;
    logic [HEX_W-1:0]         dec_hex;

    assign cur_valid = an_valid(samp.an);
    assign same      = (samp == snap_q);
    assign idx       = an_index(samp.an);

    sseg_decode u_decode (
        .pattern (samp.sseg[6:0]),
        .hit_c   (dec_hit),
        .hex_c   (dec_hex)
    );

    // Stability FSM: any fresh snapshot counts as sample 1
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        stab_cnt_d = stab_cnt_q;
        capture_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cur_valid) begin
                    state_d    = SETTLE;
                    snap_d     = samp;
                    stab_cnt_d = STAB_W'(1);
                end
            end
            SETTLE: begin
                if (!cur_valid) begin
                    state_d = IDLE;
                end else if (same) begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end else begin
                    snap_d     = samp;
                    stab_cnt_d = STAB_W'(1);
                end
            end
            HELD: begin
                if (!cur_valid) begin
                    state_d = IDLE;
                end else if (!same) begin
                    state_d    = SETTLE;
                    snap_d     = samp;
                    stab_cnt_d = STAB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Threshold reached on this edge: capture now and stop counting
        if (state_d == SETTLE && stab_cnt_d == STABLE_N) begin
            capture_c = 1'b1;
            state_d   = HELD;
        end
    end

    // Digit capture, idle timeout and frame completion
    always_comb begin
        hex_d        = hex_q;
        dp_d         = dp_q;
        valid_d      = valid_q;
        err_d        = err_q;
        seen_d       = seen_q;
        idle_cnt_d   = idle_cnt_q;
        frame_tick_d = 1'b0;
        if (capture_c) begin
            idle_cnt_d = '0;
            if (dec_hit) begin
                hex_d[idx]   = dec_hex;
                dp_d[idx]    = samp.sseg[7];
                valid_d[idx] = 1'b1;
                err_d[idx]   = 1'b0;
                seen_d[idx]  = 1'b1;
            end else begin
                err_d[idx] = 1'b1;
            end
        end else if (idle_cnt_q != TIMEOUT_N) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        // Capture on the same edge keeps the counter clear, so it wins over timeout
        if (!capture_c && idle_cnt_d == TIMEOUT_N) begin
            valid_d = '0;
            seen_d  = '0;
        end
        if (seen_d == 4'hF) begin
            frame_tick_d = 1'b1;
            seen_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= BLANK_SAMPLE;
            stab_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            hex_q        <= '0;
            dp_q         <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            seen_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            stab_cnt_q   <= stab_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            hex_q        <= hex_d;
            dp_q         <= dp_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            seen_q       <= seen_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.hex0        = hex_q[0];
    assign bus.hex1        = hex_q[1];
    assign bus.hex2        = hex_q[2];
    assign bus.hex3        = hex_q[3];
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.seg_err     = err_q;
    assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_capture.sv
// Self-checking bench for sseg_mux_capture: directed vector table, hand-written
// latency/timeout/reset sequences, and random segment streams checked against
// a segment-level reference model.
module tb_sseg_mux_capture;

    localparam int unsigned N = 16;
    localparam int unsigned T = 256;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  sseg;
        int          cyc;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic [3:0]  err;
        int          ticks;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;

    logic [6:0] ref_tbl [16];
    logic [3:0] bad_an  [6];
    vec_t       vecs    [16];

    logic [3:0] m_hex [4];
    logic [3:0] m_dp, m_valid, m_err, m_seen;
    int         m_ticks;
    int         last_c;

    always #5 clk = ~clk;

    sseg_mux_capture_if bus ();

    sseg_mux_capture #(
        .SYNC_EN        (1),
        .STABLE_CYCLES  (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.frame_tick === 1'b1) tick_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hex_all();
        return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    // Inputs change on the falling edge and are held for cyc rising edges
    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int cyc);
        bus.an   = a;
        bus.sseg = s;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hex"},   32'(hex_all()), 32'h0);
        chk({tag, "_dp"},    32'(bus.dp_out), 32'h0);
        chk({tag, "_valid"}, 32'(bus.digit_valid), 32'h0);
        chk({tag, "_err"},   32'(bus.seg_err), 32'h0);
        chk({tag, "_tick"},  32'(bus.frame_tick), 32'h0);
    endtask

    // Reference: one capture attempt at edge c for a held segment {a, s}
    task automatic model_capture(input int c, input logic [3:0] a, input logic [7:0] s);
        int idx;
        int hitv;
        if (c - last_c > int'(T)) begin
            m_valid = '0;
            m_seen  = '0;
        end
        last_c = c;
        idx = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) idx = i;
        hitv = -1;
        for (int i = 0; i < 16; i++) if (ref_tbl[i] == s[6:0]) hitv = i;
        if (hitv >= 0) begin
            m_hex[idx]   = 4'(hitv);
            m_dp[idx]    = s[7];
            m_valid[idx] = 1'b1;
            m_err[idx]   = 1'b0;
            m_seen[idx]  = 1'b1;
            if (m_seen == 4'hF) begin
                m_ticks++;
                m_seen = '0;
            end
        end else begin
            m_err[idx] = 1'b1;
        end
    endtask

    initial begin
        int         t;
        int         tk0;
        int         len;
        logic [3:0] a;
        logic [7:0] s;
        logic [11:0] prev;

        ref_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bad_an  = '{4'b1111, 4'b1100, 4'b0000, 4'b1001, 4'b0101, 4'b0011};

        vecs[0]  = '{4'b1110, 8'hF9, 64,  16'h0001, 4'b0001, 4'b0001, 4'b0000, 0};
        vecs[1]  = '{4'b1101, 8'hA4, 64,  16'h0021, 4'b0011, 4'b0011, 4'b0000, 0};
        vecs[2]  = '{4'b1011, 8'hB0, 64,  16'h0321, 4'b0111, 4'b0111, 4'b0000, 0};
        vecs[3]  = '{4'b0111, 8'h99, 64,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 1};
        vecs[4]  = '{4'b1110, 8'hF9, 64,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[5]  = '{4'b1101, 8'hA4, 64,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[6]  = '{4'b1011, 8'hB0, 64,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[7]  = '{4'b0111, 8'h99, 64,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 1};
        vecs[8]  = '{4'b1110, 8'h12, 10,  16'h4321, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[9]  = '{4'b1110, 8'hC0, 40,  16'h4320, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[10] = '{4'b1011, 8'h88, 64,  16'h4A20, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[11] = '{4'b1011, 8'hFF, 64,  16'h4A20, 4'b1111, 4'b1111, 4'b0100, 0};
        vecs[12] = '{4'b1011, 8'hC6, 64,  16'h4C20, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[13] = '{4'b1111, 8'hFF, 100, 16'h4C20, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[14] = '{4'b1100, 8'hC6, 100, 16'h4C20, 4'b1111, 4'b1111, 4'b0000, 0};
        vecs[15] = '{4'b1111, 8'hFF, 300, 16'h4C20, 4'b1111, 4'b0000, 4'b0000, 0};

        // Reset state
        rst      = 1'b1;
        bus.an   = 4'hF;
        bus.sseg = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            tk0 = tick_cnt;
            drive(vecs[i].an, vecs[i].sseg, vecs[i].cyc);
            chk($sformatf("vec%0d_hex", i),   32'(hex_all()),        32'(vecs[i].hex));
            chk($sformatf("vec%0d_dp", i),    32'(bus.dp_out),       32'(vecs[i].dp));
            chk($sformatf("vec%0d_valid", i), 32'(bus.digit_valid),  32'(vecs[i].valid));
            chk($sformatf("vec%0d_err", i),   32'(bus.seg_err),      32'(vecs[i].err));
            chk($sformatf("vec%0d_ticks", i), 32'(tick_cnt - tk0),   32'(vecs[i].ticks));
        end

        // Capture latency: 2 sync cycles plus N stable samples
        do_reset();
        drive(4'b1110, 8'hF8, 17);
        chk("lat_before_hex", 32'(bus.hex0), 32'h0);
        chk("lat_before_valid", 32'(bus.digit_valid), 32'h0);
        drive(4'b1110, 8'hF8, 1);
        chk("lat_at_hex", 32'(bus.hex0), 32'h7);
        chk("lat_at_valid", 32'(bus.digit_valid), 32'h1);

        // Timeout boundary: last capture 18 edges into the fourth 64-cycle step
        do_reset();
        tk0 = tick_cnt;
        for (int i = 0; i < 4; i++) drive(vecs[i].an, vecs[i].sseg, 64);
        drive(4'hF, 8'hFF, 209);
        chk("to_idle255_valid", 32'(bus.digit_valid), 32'hF);
        drive(4'hF, 8'hFF, 1);
        chk("to_idle256_valid", 32'(bus.digit_valid), 32'h0);
        drive(4'hF, 8'hFF, 90);
        chk("to_hex_kept", 32'(hex_all()), 32'h4321);
        chk("to_valid_stay", 32'(bus.digit_valid), 32'h0);
        chk("to_ticks", 32'(tick_cnt - tk0), 32'd1);

        // Reset in the middle of a frame
        do_reset();
        drive(4'b1110, 8'hF9, 64);
        drive(4'b1101, 8'hA4, 64);
        chk("mid_valid", 32'(bus.digit_valid), 32'h3);
        tk0 = tick_cnt;
        do_reset();
        chk_zero("mid_rst");
        drive(4'b1011, 8'hB0, 64);
        drive(4'b0111, 8'h99, 64);
        chk("mid_no_tick", 32'(tick_cnt - tk0), 32'd0);
        chk("mid_valid23", 32'(bus.digit_valid), 32'hC);
        drive(4'b1110, 8'hF9, 64);
        drive(4'b1101, 8'hA4, 64);
        chk("mid_one_tick", 32'(tick_cnt - tk0), 32'd1);
        chk("mid_hex", 32'(hex_all()), 32'h4321);

        // Random segment streams against the reference model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 4; i++) m_hex[i] = '0;
            m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0;
            m_ticks = 0;
            last_c = 0;
            t = 0;
            tk0 = tick_cnt;
            prev = 12'hFFF;
            for (int k = 0; k <= 60; k++) begin
                do begin
                    if (k == 60 || $urandom_range(0, 3) != 0)
                        a = ~(4'(1) << $urandom_range(0, 3));
                    else
                        a = bad_an[$urandom_range(0, 5)];
                    if (k == 60 || $urandom_range(0, 9) < 7)
                        s = {1'($urandom_range(0, 1)), ref_tbl[$urandom_range(0, 15)]};
                    else
                        s = 8'($urandom);
                end while ({a, s} == prev);
                len = (k == 60) ? 30 : int'($urandom_range(1, 40));
                if ($countones(~a) == 1 && len >= int'(N))
                    model_capture(t + 2 + int'(N), a, s);
                drive(a, s, len);
                t += len;
                prev = {a, s};
            end
            chk($sformatf("rnd%0d_hex", r),   32'(hex_all()),
                32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
            chk($sformatf("rnd%0d_dp", r),    32'(bus.dp_out),      32'(m_dp));
            chk($sformatf("rnd%0d_valid", r), 32'(bus.digit_valid), 32'(m_valid));
            chk($sformatf("rnd%0d_err", r),   32'(bus.seg_err),     32'(m_err));
            chk($sformatf("rnd%0d_ticks", r), 32'(tick_cnt - tk0),  32'(m_ticks));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
